// File: rtl/prog_loader.sv
// prog_loader: holds the CPU in reset, streams a block of words into instruction memory, settles, then releases the CPU.
module prog_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              InsWrEN,
  output logic [ADDR_W-1:0] InsWrAddr,
  output logic [DATA_W-1:0] InsDataIn,
  output logic              cpu_nclear,
  output logic              cpu_nRST,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] remaining;
  logic [7:0] settleCnt;
  assign in_ready = state == LOAD;
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      ptr <= '0;
      remaining <= '0;
      settleCnt <= '0;
      InsWrEN <= 1'b0;
      InsWrAddr <= '0;
      InsDataIn <= '0;
      cpu_nclear <= 1'b0;
      cpu_nRST <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      InsWrEN <= 1'b0;
      err <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cpu_nclear <= 1'b0;
        cpu_nRST <= 1'b0;
        busy <= 1'b0;
        done <= 1'b0;
      end else
        case (state)
          IDLE:
            if (start) begin
              if (word_cnt > (ADDR_W+1)'(DEPTH))
                err <= 1'b1;
              else if (word_cnt == '0) begin
                state <= SETTLE;
                settleCnt <= 8'(SETTLE_CYC - 1);
                busy <= 1'b1;
              end else begin
                state <= LOAD;
                ptr <= base_addr;
                remaining <= word_cnt;
                busy <= 1'b1;
              end
            end
          LOAD:
            if (in_valid) begin
              InsWrEN <= 1'b1;
              InsWrAddr <= ptr;
              InsDataIn <= in_data;
              ptr <= ptr + 1'b1;
              remaining <= remaining - 1'b1;
              if (remaining == (ADDR_W+1)'(1)) begin
                state <= SETTLE;
                settleCnt <= 8'(SETTLE_CYC - 1);
              end
            end
          SETTLE:
            if (settleCnt == '0) begin
              state <= RUN;
              busy <= 1'b0;
              done <= 1'b1;
              cpu_nclear <= 1'b1;
              cpu_nRST <= 1'b1;
            end else
              settleCnt <= settleCnt - 1'b1;
          default: ;
        endcase
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader between a word stream source (bench, UART, debug port) and the MIPS_CPU instruction-memory write port and CPU reset/clear inputs.
- Holds the CPU in reset, writes a block of instruction words into consecutive instruction-memory addresses using a valid/ready handshake, waits a programmable settle time, then releases the CPU.
- Parametrised successor to hand-driven instruction loading: configurable width, depth, base address and word count, with address wrap-around, abort and error reporting.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 5, instruction-memory address width; DEPTH = 2**ADDR_W.
- SETTLE_CYC, 2, cycles spent in SETTLE before CPU release; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  return to IDLE and re-hold CPU in reset; highest priority.
- base_addr  in  ADDR_W  first write address, latched on accepted start.
- word_cnt  in  ADDR_W+1  number of words to load, 0..DEPTH, latched on accepted start.
- in_valid  in  1  in_data holds a word.
- in_data  in  DATA_W  instruction word.
- in_ready  out  1  loader accepts a word this cycle.
- InsWrEN  out  1  instruction-memory write enable, one-cycle pulse per word.
- InsWrAddr  out  ADDR_W  instruction-memory write address.
- InsDataIn  out  DATA_W  instruction-memory write data.
- cpu_nclear  out  1  to CPU nclear; 0 = held.
- cpu_nRST  out  1  to CPU nRST; 0 = held.
- busy  out  1  state is LOAD or SETTLE.
- done  out  1  state is RUN.
- err  out  1  one-cycle pulse: rejected start.

Behaviour:
- States: IDLE, LOAD, SETTLE, RUN. All outputs registered except in_ready, which is Moore (in_ready = state==LOAD).
- Reset (nRST=0, asynchronous): state IDLE; InsWrEN, InsWrAddr, InsDataIn, cpu_nclear, cpu_nRST, busy, done and err all 0.
- IDLE: CPU held (cpu_nclear = cpu_nRST = 0).
  - start with word_cnt > DEPTH: err=1 for exactly one cycle; state stays IDLE.
  - start with word_cnt 1..DEPTH: latch base_addr into the address pointer and word_cnt into the remaining counter; go to LOAD.
  - start with word_cnt = 0: go directly to SETTLE.
- LOAD: each cycle with in_valid & in_ready is a transfer.
  - Cycle after a transfer: InsWrEN=1, InsWrAddr=pointer, InsDataIn=word. InsWrEN=0 on all other cycles.
  - Per transfer: pointer increments modulo DEPTH (DEPTH-1 wraps to 0); remaining decrements.
  - The transfer that brings remaining to 0 moves the state to SETTLE, so in_ready is 0 from the next cycle.
  - in_valid low inserts gaps with no write and no count change; no timeout.
- SETTLE: lasts exactly SETTLE_CYC cycles, counted from entry. The final write pulse coincides with the first SETTLE cycle. Then go to RUN.
- RUN: cpu_nclear = cpu_nRST = 1, done=1. Stays until abort or reset; start is ignored.
- start is ignored in LOAD, SETTLE and RUN; no err is raised.
- abort in any state: next cycle state IDLE, CPU held, InsWrEN=0. A transfer in the same cycle as abort is dropped (no write pulse). abort with start in IDLE: abort wins.
- Async reset mid-LOAD: any pending write pulse is cancelled immediately. No partial state survives reset.

Test Plan:
- ADDR_W=5, SETTLE_CYC=2; start, base 1, count 3; stream 0x00211020, 0x00221820, 0x00622022 with no gaps -> three InsWrEN pulses at addresses 1, 2, 3 with matching data; cpu_nRST/cpu_nclear/done rise 2 cycles after the last write pulse; in_ready low after the 3rd transfer.
- Wrap-around: base 30, count 4, words 0xA..0xD -> writes at addresses 30, 31, 0, 1 with data A, B, C, D; then RUN.
- Backpressure: base 0, count 2; in_valid toggles 1,0,0,1 -> exactly two write pulses, separated by the gap cycles; remaining count unaffected by gaps.
- Count 0 -> no InsWrEN; SETTLE for 2 cycles; done=1 on the 3rd cycle after the start cycle. Count 33 -> err high for exactly 1 cycle; state IDLE; no writes; CPU still held.
- Abort after 2 of 5 words, including abort asserted on a transfer cycle -> that word is not written; IDLE next cycle; cpu_nRST=0. A new start afterwards reloads from the new base.
- nRST pulsed low mid-LOAD and mid-RUN -> all outputs 0 immediately (asynchronous, not waiting for clk); IDLE after release; a subsequent load completes normally.
